// File: rtl/axis_gen_burst_ctrl.sv
// Burst scheduler for the AXI-Stream counter generator: runs pkt_num packets of
// pkt_len beats separated by gap idle cycles, with graceful stop and done pulse.
module axis_gen_burst_ctrl #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                       clk_i,
  input  logic                       a_rst_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [LEN_WIDTH-1:0]       pkt_len_i,
  input  logic [LEN_WIDTH-1:0]       pkt_num_i,
  input  logic [LEN_WIDTH-1:0]       gap_i,
  output logic                       gen_enable_o,
  output logic [AXIS_DATA_WIDTH-1:0] gen_data_o,
  output logic                       gen_terminal_o,
  input  logic                       gen_counter_enable_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [LEN_WIDTH-1:0]       pkt_cnt_o
);

  // state | meaning
  // IDLE  | waiting for start_i, config inputs latched on start
  // SEND  | presenting beats of the current packet to the generator
  // GAP   | idle cycles between packets, gap_cnt counts down to 1
  // DONE  | one-cycle done_o pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_m1_q, len_m1_d;
  logic [LEN_WIDTH-1:0] num_q, num_d;
  logic [LEN_WIDTH-1:0] gap_q, gap_d;
  logic [LEN_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [LEN_WIDTH-1:0] pkt_idx_q, pkt_idx_d;
  logic [LEN_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 terminal;
  logic                 acc;

  assign terminal = (beat_q == len_m1_q);
  assign acc      = (state_q == S_SEND) && gen_counter_enable_i;

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_q     <= S_IDLE;
      len_m1_q    <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      beat_q      <= '0;
      pkt_idx_q   <= '0;
      pkt_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_m1_q    <= len_m1_d;
      num_q       <= num_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      beat_q      <= beat_d;
      pkt_idx_q   <= pkt_idx_d;
      pkt_cnt_q   <= pkt_cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_m1_d    = len_m1_q;
    num_d       = num_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    beat_d      = beat_q;
    pkt_idx_d   = pkt_idx_q;
    pkt_cnt_d   = pkt_cnt_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start_i) begin
          len_m1_d  = (pkt_len_i == '0) ? '0 : pkt_len_i - ONE;
          num_d     = pkt_num_i;
          gap_d     = gap_i;
          beat_d    = '0;
          pkt_idx_d = '0;
          pkt_cnt_d = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (acc) begin
          if (terminal) begin
            beat_d    = '0;
            pkt_idx_d = pkt_idx_q + ONE;
            pkt_cnt_d = pkt_cnt_q + ONE;
            // a stop arriving on the terminal beat itself also ends the burst
            if (stop_pend_q || stop_i || ((num_q != '0) && (pkt_cnt_d == num_q))) begin
              state_d = S_DONE;
            end else if (gap_q != '0) begin
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end
          end else begin
            beat_d = beat_q + ONE;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - ONE;
        if (stop_i || stop_pend_q) state_d = S_DONE;
        else if (gap_cnt_q == ONE) state_d = S_SEND;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign gen_enable_o   = (state_q == S_SEND);
  assign gen_terminal_o = (state_q == S_SEND) && terminal;
  assign gen_data_o     = AXIS_DATA_WIDTH'({pkt_idx_q, beat_q});
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign pkt_cnt_o      = pkt_cnt_q;

endmodule

// File: tb/tb_axis_gen_burst_ctrl.sv
// Directed bench for axis_gen_burst_ctrl: per-cycle vector table plus
// hand-written sequences for backpressure, stop and reset corner cases.
module tb_axis_gen_burst_ctrl;

  logic        clk_i = 1'b0;
  logic        a_rst_i;
  logic        start_i, stop_i, tready;
  logic [15:0] pkt_len_i, pkt_num_i, gap_i;
  logic        gen_enable_o, gen_terminal_o, busy_o, done_o;
  logic [31:0] gen_data_o;
  logic [15:0] pkt_cnt_o;

  axis_gen_burst_ctrl #(.AXIS_DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i(clk_i), .a_rst_i(a_rst_i), .start_i(start_i), .stop_i(stop_i),
    .pkt_len_i(pkt_len_i), .pkt_num_i(pkt_num_i), .gap_i(gap_i),
    .gen_enable_o(gen_enable_o), .gen_data_o(gen_data_o),
    .gen_terminal_o(gen_terminal_o), .gen_counter_enable_i(tready),
    .busy_o(busy_o), .done_o(done_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          start, stop, rdy;
    logic [15:0] len, num, gap;
    bit          en;
    logic [31:0] data;
    bit          last, busy, done;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit st, bit sp, bit rdy, int len, int num, int gap,
                              bit en, int data, bit last, bit busy, bit done, int cnt);
    vec_t v;
    v.start = st; v.stop = sp; v.rdy = rdy;
    v.len = 16'(len); v.num = 16'(num); v.gap = 16'(gap);
    v.en = en; v.data = 32'(data); v.last = last;
    v.busy = busy; v.done = done; v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_i);
      chk($sformatf("v%0d en", i), 32'(gen_enable_o), 32'(vq[i].en));
      if (vq[i].en) chk($sformatf("v%0d data", i), gen_data_o, vq[i].data);
      chk($sformatf("v%0d last", i), 32'(gen_terminal_o), 32'(vq[i].last));
      chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(vq[i].busy));
      chk($sformatf("v%0d done", i), 32'(done_o), 32'(vq[i].done));
      chk($sformatf("v%0d cnt", i), 32'(pkt_cnt_o), 32'(vq[i].cnt));
      start_i = vq[i].start; stop_i = vq[i].stop; tready = vq[i].rdy;
      pkt_len_i = vq[i].len; pkt_num_i = vq[i].num; gap_i = vq[i].gap;
    end
  endtask

  initial begin
    int  exp_beat, acc_n, last_n, term_n;
    bit  seen_done, stopped;
    logic [31:0] last_data;

    a_rst_i = 1'b1; start_i = 0; stop_i = 0; tready = 0;
    pkt_len_i = 0; pkt_num_i = 0; gap_i = 0;

    // len=4 num=2 gap=0: 8 back-to-back beats; start/config changes while busy ignored
    vq.push_back(mk(1,0,1,4,2,0, 0,0,0,0,0,0));
    for (int b = 0; b < 4; b++) vq.push_back(mk(1,0,1,9,9,9, 1,b,(b==3),1,0,0));
    for (int b = 0; b < 4; b++) vq.push_back(mk(1,0,1,9,9,9, 1,32'h10000+b,(b==3),1,0,1));
    vq.push_back(mk(0,0,1,4,2,0, 0,0,0,1,1,2));
    // len=3 num=2 gap=5: count held in IDLE until start, 5 idle cycles between packets
    vq.push_back(mk(1,0,1,3,2,5, 0,0,0,0,0,2));
    for (int b = 0; b < 3; b++) vq.push_back(mk(0,0,1,3,2,5, 1,b,(b==2),1,0,0));
    for (int g = 0; g < 5; g++) vq.push_back(mk(1,0,1,7,7,7, 0,0,0,1,0,1));
    for (int b = 0; b < 3; b++) vq.push_back(mk(0,0,1,3,2,5, 1,32'h10000+b,(b==2),1,0,1));
    vq.push_back(mk(0,0,1,3,2,5, 0,0,0,1,1,2));
    // len=0 behaves as len=1: every beat is terminal
    vq.push_back(mk(1,0,1,0,3,0, 0,0,0,0,0,2));
    for (int p = 0; p < 3; p++) vq.push_back(mk(0,0,1,0,3,0, 1,p*32'h10000,1,1,0,p));
    vq.push_back(mk(0,0,1,0,3,0, 0,0,0,1,1,3));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,3));

    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst en", 32'(gen_enable_o), 32'd0);
    chk("rst data", gen_data_o, 32'd0);
    chk("rst last", 32'(gen_terminal_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst cnt", 32'(pkt_cnt_o), 32'd0);
    a_rst_i = 1'b0;

    run_table();

    // backpressure: tready toggles, beat held while not accepted
    @(negedge clk_i);
    start_i = 1; pkt_len_i = 4; pkt_num_i = 1; gap_i = 0; tready = 0;
    exp_beat = 0; acc_n = 0; last_n = 0; seen_done = 0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      @(negedge clk_i);
      start_i = 0;
      if (done_o) seen_done = 1;
      else if (gen_enable_o) begin
        chk("bp data", gen_data_o, 32'(exp_beat));
        chk("bp last", 32'(gen_terminal_o), 32'(exp_beat == 3));
        tready = ~tready;
        if (tready) begin
          acc_n++;
          if (gen_terminal_o) last_n++;
          exp_beat++;
        end
      end
    end
    if (!seen_done) timeout("bp done");
    chk("bp accepts", 32'(acc_n), 32'd4);
    chk("bp lasts", 32'(last_n), 32'd1);
    chk("bp cnt", 32'(pkt_cnt_o), 32'd1);

    // infinite burst, stop during packet 2, start held high while busy
    @(negedge clk_i);
    tready = 1; start_i = 1; pkt_len_i = 2; pkt_num_i = 0; gap_i = 2;
    stopped = 0; seen_done = 0; term_n = 0; last_data = '1;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      @(negedge clk_i);
      stop_i = 0;
      if (done_o) begin
        seen_done = 1;
        start_i = 0;
      end else if (gen_enable_o) begin
        last_data = gen_data_o;
        if (gen_terminal_o) term_n++;
        if (gen_data_o == 32'h20000 && !stopped) begin
          stop_i = 1;
          stopped = 1;
        end
      end
    end
    if (!seen_done) timeout("stop done");
    chk("stop cnt", 32'(pkt_cnt_o), 32'd3);
    chk("stop terms", 32'(term_n), 32'd3);
    chk("stop lastbeat", last_data, 32'h20001);
    @(negedge clk_i);
    chk("stop done pulse", 32'(done_o), 32'd0);
    chk("stop busy", 32'(busy_o), 32'd0);

    // stop in GAP ends the burst on the next cycle
    start_i = 1; pkt_len_i = 1; pkt_num_i = 0; gap_i = 3;
    @(negedge clk_i);
    chk("gstop en", 32'(gen_enable_o), 32'd1);
    chk("gstop last", 32'(gen_terminal_o), 32'd1);
    start_i = 0;
    @(negedge clk_i);
    chk("gstop gap en", 32'(gen_enable_o), 32'd0);
    chk("gstop gap busy", 32'(busy_o), 32'd1);
    stop_i = 1;
    @(negedge clk_i);
    stop_i = 0;
    chk("gstop done", 32'(done_o), 32'd1);
    chk("gstop cnt", 32'(pkt_cnt_o), 32'd1);
    @(negedge clk_i);
    chk("gstop idle", 32'(busy_o), 32'd0);

    // async reset mid-SEND, then restart from packet 0
    start_i = 1; pkt_len_i = 5; pkt_num_i = 0; gap_i = 0;
    @(negedge clk_i);
    start_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre-rst data", gen_data_o, 32'd2);
    #2 a_rst_i = 1;
    #1;
    chk("arst en", 32'(gen_enable_o), 32'd0);
    chk("arst busy", 32'(busy_o), 32'd0);
    chk("arst data", gen_data_o, 32'd0);
    chk("arst last", 32'(gen_terminal_o), 32'd0);
    @(negedge clk_i);
    a_rst_i = 0; start_i = 1; pkt_len_i = 2; pkt_num_i = 1;
    @(negedge clk_i);
    start_i = 0;
    chk("restart en", 32'(gen_enable_o), 32'd1);
    chk("restart data", gen_data_o, 32'd0);
    @(negedge clk_i);
    chk("restart data1", gen_data_o, 32'd1);
    chk("restart last", 32'(gen_terminal_o), 32'd1);
    @(negedge clk_i);
    chk("restart done", 32'(done_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_gen_burst_ctrl.md
# axis_gen_burst_ctrl

Burst scheduler for the AXI-Stream counter-based data generator. Sequences the generator through a programmed number of packets of programmed length, separated by a programmed idle gap. Supplies the generator's beat data and last-beat flag, and consumes its beat-accept strobe. Sits between the register/control plane (start/stop/config) and the generator in the UDP filter test datapath.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 32: width of generated beat data; must be ≥ 2*LEN_WIDTH.
- LEN_WIDTH, 16: width of packet length, packet count and gap fields.

Ports:
- clk_i  in  1  sole clock; all logic on rising edge.
- a_rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- stop_i  in  1  graceful stop request; honored only in SEND and GAP.
- pkt_len_i  in  LEN_WIDTH  beats per packet; 0 is treated as 1.
- pkt_num_i  in  LEN_WIDTH  packets per burst; 0 means run until stop.
- gap_i  in  LEN_WIDTH  idle cycles between packets; 0 means back-to-back.
- gen_enable_o  out  1  drives the generator enable (becomes tvalid).
- gen_data_o  out  AXIS_DATA_WIDTH  beat data: {zeros, pkt_idx[LEN_WIDTH-1:0], beat_idx[LEN_WIDTH-1:0]}.
- gen_terminal_o  out  1  last beat of current packet (becomes tlast).
- gen_counter_enable_i  in  1  generator beat-accept strobe (tready).
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a burst completes.
- pkt_cnt_o  out  LEN_WIDTH  packets fully sent in the current or last burst.

## Operation
- States: IDLE, SEND, GAP, DONE. Reset state is IDLE.
- Beat accept: acc = gen_enable_o & gen_counter_enable_i.
- IDLE:
  - start_i=1 latches len_m1 = max(pkt_len_i,1)-1, pkt_num_i and gap_i.
  - Clears beat_idx, pkt_idx and pkt_cnt_o, then goes to SEND.
  - Config inputs are ignored outside IDLE.
- SEND:
  - gen_enable_o=1.
  - gen_terminal_o = (beat_idx == len_m1).
  - Each acc increments beat_idx.
  - acc on the terminal beat:
    - beat_idx←0, pkt_idx+1, pkt_cnt_o+1.
    - Next state, in priority order: DONE if stop is pending, or pkt_num≠0 and pkt_cnt_o+1 == pkt_num; GAP if gap≠0 (gap counter loaded with gap); otherwise stay in SEND.
- GAP:
  - gen_enable_o=0.
  - Gap counter decrements each cycle; at 1, next state is SEND.
  - stop_i, or a pending stop, goes to DONE next cycle.
- DONE: done_o=1 for one cycle, then IDLE. pkt_cnt_o holds until the next start.
- Stop:
  - stop_i in SEND sets a sticky stop_pend.
  - The current packet always completes; packets are never truncated.
  - stop_pend clears in IDLE.
- Wrap-around:
  - pkt_idx and pkt_cnt_o wrap modulo 2^LEN_WIDTH in infinite mode.
  - The pkt_num compare uses the full LEN_WIDTH value.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The current packet is abandoned.

## Timing
- Reset values: gen_enable_o=0, gen_data_o=0, gen_terminal_o=0, busy_o=0, done_o=0, pkt_cnt_o=0.
- All outputs are registered state or decode of registered state only. There is no combinational path from gen_counter_enable_i to any output.
- start_i high at edge N puts gen_enable_o high from cycle N+1.
- gen_data_o and gen_terminal_o are stable while gen_enable_o=1 and acc=0 (backpressure holds the beat).
- Back-to-back (gap=0): the first beat of the next packet is presented the cycle after the terminal acc, with no bubble.
- Gap: exactly gap_i cycles with gen_enable_o=0 between the terminal acc and the next first beat.
- done_o asserts the cycle after the final terminal acc, or after stop in GAP.
- busy_o deasserts the cycle after done_o.

## Test plan
- len=4, num=2, gap=0, tready=1: 8 consecutive beats, beat_idx 0..3 twice, tlast on beats 3 and 7, done_o pulse, pkt_cnt_o=2.
- len=3, num=2, gap=5, tready=1: 5-cycle gap between packets, data 0x0000_0000..0x0000_0002 then 0x0001_0000..0x0001_0002.
- len=4, tready toggling 1/0: each beat held stable while tready=0, exactly 4 accepted beats per packet, tlast only on the 4th.
- num=0 (infinite), stop_i mid-packet 2: packet 2 completes, done_o pulses, pkt_cnt_o=3; start_i during busy is ignored.
- len=0: every beat carries tlast. a_rst_i asserted mid-SEND: gen_enable_o=0 and busy_o=0 immediately; a subsequent start restarts from pkt_idx 0.
